// File: rtl/imem_boot_loader.sv
// Boot loader: streams a length-prefixed program image into instruction memory, then enables the cpu.
// Optional readback verify pass over the loaded image: define LOADER_VERIFY_EN.

module imem_boot_loader #(
  parameter int unsigned DEPTH     = 512,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] ADDR_STEP = 32'd4
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        start,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  output logic [31:0] addr_ext,
  output logic        wen_ext,
  output logic [31:0] wdata_ext,
  output logic        ren_ext,
  input  logic [31:0] rdata_ext,
  output logic        cpu_enable,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    LOAD,
`ifdef LOADER_VERIFY_EN
    VERIFY,
`endif
    RUN,
    ERR
  } state_t;

  state_t        state;
  logic [CW-1:0] len;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic [31:0]   csum;
  logic          xfer;
  logic          hdr_ok;

  assign xfer    = s_valid & s_ready;
  assign cnt_inc = cnt + CW'(1);
  assign hdr_ok  = (s_data != '0) && (s_data <= 32'(DEPTH));

  function automatic logic [31:0] addr_of(input logic [CW-1:0] k);
    return BASE_ADDR + 32'(k) * ADDR_STEP;
  endfunction

`ifdef LOADER_VERIFY_EN
  logic        rd_valid;
  logic [31:0] rsum;
`else
  logic unused_rd;
  assign ren_ext   = 1'b0;
  assign unused_rd = ^{rdata_ext, csum};
`endif

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state      <= IDLE;
      len        <= '0;
      cnt        <= '0;
      csum       <= '0;
      s_ready    <= 1'b0;
      addr_ext   <= '0;
      wen_ext    <= 1'b0;
      wdata_ext  <= '0;
      cpu_enable <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
`ifdef LOADER_VERIFY_EN
      ren_ext    <= 1'b0;
      rd_valid   <= 1'b0;
      rsum       <= '0;
`endif
    end else begin
      wen_ext <= 1'b0;
`ifdef LOADER_VERIFY_EN
      ren_ext  <= 1'b0;
      rd_valid <= ren_ext;
`endif
      case (state)
        IDLE, RUN, ERR: begin
          if (start) begin
            state      <= HDR;
            cnt        <= '0;
            csum       <= '0;
            s_ready    <= 1'b1;
            busy       <= 1'b1;
            cpu_enable <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
          end
        end
        HDR: begin
          if (xfer) begin
            if (hdr_ok) begin
              state <= LOAD;
              len   <= CW'(s_data);
              cnt   <= '0;
            end else begin
              state   <= ERR;
              s_ready <= 1'b0;
              busy    <= 1'b0;
              error   <= 1'b1;
            end
          end
        end
        LOAD: begin
          // cnt == len with a live write pulse means the final word is being written now
          if (wen_ext && cnt == len) begin
`ifdef LOADER_VERIFY_EN
            state    <= VERIFY;
            ren_ext  <= 1'b1;
            addr_ext <= BASE_ADDR;
            cnt      <= CW'(1);
            rsum     <= '0;
`else
            state      <= RUN;
            busy       <= 1'b0;
            cpu_enable <= 1'b1;
            done       <= 1'b1;
`endif
          end else if (xfer) begin
            wen_ext   <= 1'b1;
            addr_ext  <= addr_of(cnt);
            wdata_ext <= s_data;
            csum      <= csum ^ s_data;
            cnt       <= cnt_inc;
            if (cnt_inc == len) s_ready <= 1'b0;
          end
        end
`ifdef LOADER_VERIFY_EN
        VERIFY: begin
          if (cnt != len) begin
            ren_ext  <= 1'b1;
            addr_ext <= addr_of(cnt);
            cnt      <= cnt_inc;
          end
          // read data trails its request by one cycle; last sample arrives once requests stop
          if (rd_valid) begin
            rsum <= rsum ^ rdata_ext;
            if (!ren_ext) begin
              busy <= 1'b0;
              if ((rsum ^ rdata_ext) == csum) begin
                state      <= RUN;
                cpu_enable <= 1'b1;
                done       <= 1'b1;
              end else begin
                state <= ERR;
                error <= 1'b1;
              end
            end
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomized scoreboard bench for imem_boot_loader: expected writes are queued as words are sent,
// a negedge monitor pops and compares each write pulse against the queue.

module tb_imem_boot_loader;

  localparam int unsigned DEPTH = 512;
`ifdef LOADER_VERIFY_EN
  localparam bit VERIFY_ON = 1'b1;
`else
  localparam bit VERIFY_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        arst_n;
  logic        start;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic [31:0] addr_ext;
  logic        wen_ext;
  logic [31:0] wdata_ext;
  logic        ren_ext;
  logic [31:0] rdata_ext = 32'h0;
  logic        cpu_enable;
  logic        busy;
  logic        done;
  logic        error;

  imem_boot_loader #(
    .DEPTH    (DEPTH),
    .BASE_ADDR(32'h0000_0000),
    .ADDR_STEP(32'd4)
  ) dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .start     (start),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .addr_ext  (addr_ext),
    .wen_ext   (wen_ext),
    .wdata_ext (wdata_ext),
    .ren_ext   (ren_ext),
    .rdata_ext (rdata_ext),
    .cpu_enable(cpu_enable),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int unsigned cyc;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         e;
  logic [31:0] wq[$];
  logic [31:0] mem [0:DEPTH-1];
  logic [31:0] corrupt_addr = 32'hFFFF_FFFF;
  int unsigned cyc = 0;
  int unsigned nwrites = 0;
  int unsigned last_wr_cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          busy_watch = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int unsigned vextra(input int unsigned n);
    return VERIFY_ON ? n + 1 : 0;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // instruction memory model; corrupt_addr flips bit 0 on the read path only
  always @(posedge clk) begin
    if (wen_ext) mem[addr_ext[10:2]] <= wdata_ext;
    if (ren_ext) rdata_ext <= mem[addr_ext[10:2]] ^ ((addr_ext == corrupt_addr) ? 32'h1 : 32'h0);
  end

  always @(negedge clk) begin
    if (busy_watch) chk("busy_during_load", 32'(busy), 32'd1);
    if (wen_ext) begin
      nwrites++;
      last_wr_cyc = cyc;
      chk("cpu_en_during_write", 32'(cpu_enable), 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_write_addr", addr_ext, 32'hxxxx_xxxx);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", addr_ext, e.addr);
        chk("wr_data", wdata_ext, e.data);
        chk("wr_latency", cyc, e.cyc);
      end
    end
  end

  task automatic pulse_start(input bit check);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (check) begin
      @(negedge clk);
      chk("start_status", 32'({cpu_enable, done, error, busy, s_ready}), 32'b00011);
      @(posedge clk); #1;
    end
  endtask

  task automatic send_word(input logic [31:0] d, input int unsigned gaps,
                           output bit ok, output int unsigned acc);
    logic rdy;
    ok  = 1'b0;
    acc = 0;
    s_valid = 1'b0;
    repeat (gaps) begin @(posedge clk); #1; end
    s_valid = 1'b1;
    s_data  = d;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      rdy = s_ready;
      acc = cyc + 1;
      @(posedge clk); #1;
      if (rdy) ok = 1'b1;
    end
    s_valid = 1'b0;
    chk("accept", 32'(ok), 32'd1);
  endtask

  task automatic run_load(input logic [31:0] hdr, input int unsigned gmin, input int unsigned gmax,
                          input bit mid_start, input bit watch);
    bit          ok;
    bit          hdr_ok;
    bit          good;
    bit          fin;
    int unsigned acc;
    int unsigned n0;
    hdr_ok = (hdr >= 1) && (hdr <= DEPTH);
    good   = hdr_ok;
    if (VERIFY_ON && hdr_ok && corrupt_addr < hdr * 4) good = 1'b0;
    n0 = nwrites;
    pulse_start(1'b1);
    busy_watch = watch;
    send_word(hdr, 0, ok, acc);
    if (hdr_ok) begin
      for (int unsigned k = 0; k < hdr; k++) begin
        if (mid_start && k == hdr / 2) pulse_start(1'b0);
        send_word(wq[k], $urandom_range(gmax, gmin), ok, acc);
        exp_q.push_back('{addr: 32'(k * 4), data: wq[k], cyc: acc});
      end
    end
    busy_watch = 1'b0;
    fin = 1'b0;
    for (int i = 0; i < 3000 && !fin; i++) begin
      @(negedge clk);
      fin = done | error;
    end
    chk("finish_seen", 32'(fin), 32'd1);
    chk("final_status", 32'({cpu_enable, done, error, busy}), good ? 32'b1100 : 32'b0010);
    if (hdr_ok) chk("finish_latency", cyc, last_wr_cyc + 1 + vextra(hdr));
    else        chk("no_write_on_bad_hdr", nwrites, n0);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    s_valid = 1'b1;
    s_data  = $urandom;
    repeat (2) begin
      @(negedge clk);
      chk("ready_low_after", 32'(s_ready), 32'd0);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic fill(input int unsigned n);
    wq.delete();
    for (int unsigned k = 0; k < n; k++) wq.push_back($urandom);
  endtask

  initial begin
    bit          ok;
    int unsigned acc;
    arst_n  = 1'b0;
    start   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_addr", addr_ext, 32'h0);
    chk("rst_wdata", wdata_ext, 32'h0);
    chk("rst_flags", 32'({s_ready, wen_ext, ren_ext, cpu_enable, busy, done, error}), 32'h0);
    #2 arst_n = 1'b1;
    @(posedge clk); #1;

    wq = '{32'h2001_0005, 32'h2002_0007, 32'h0022_1820};
    run_load(32'd3, 0, 0, 1'b0, 1'b0);

    wq.delete();
    run_load(32'd0, 0, 0, 1'b0, 1'b0);
    wq = '{32'hDEAD_BEEF};
    run_load(32'd1, 0, 0, 1'b0, 1'b0);

    run_load(32'd513, 0, 0, 1'b0, 1'b0);
    fill(512);
    run_load(32'd512, 0, 0, 1'b0, 1'b0);

    fill(4);
    run_load(32'd4, 1, 1, 1'b0, 1'b1);

    for (int r = 0; r < 8; r++) begin
      int unsigned n;
      n = $urandom_range(12, 1);
      fill(n);
      run_load(n, 0, 2, 1'($urandom_range(1, 0)), 1'b0);
    end

    run_load(32'hFFFF_FFFF, 0, 0, 1'b0, 1'b0);

    // asynchronous reset after 2 of 4 words
    fill(4);
    pulse_start(1'b1);
    send_word(32'd4, 0, ok, acc);
    for (int unsigned k = 0; k < 2; k++) begin
      send_word(wq[k], 0, ok, acc);
      exp_q.push_back('{addr: 32'(k * 4), data: wq[k], cyc: acc});
    end
    @(negedge clk);
    @(posedge clk); #3;
    arst_n = 1'b0;
    #1;
    chk("async_rst_addr", addr_ext, 32'h0);
    chk("async_rst_wdata", wdata_ext, 32'h0);
    chk("async_rst_flags", 32'({s_ready, wen_ext, ren_ext, cpu_enable, busy, done, error}), 32'h0);
    @(negedge clk);
    arst_n  = 1'b1;
    s_valid = 1'b1;
    s_data  = wq[2];
    repeat (4) begin
      @(negedge clk);
      chk("ready_after_reset", 32'(s_ready), 32'd0);
    end
    s_valid = 1'b0;
    chk("idle_after_reset", 32'({busy, done, error, cpu_enable}), 32'h0);
    chk("sb_drained_reset", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;

`ifdef LOADER_VERIFY_EN
    corrupt_addr = 32'd4;
    fill(3);
    run_load(32'd3, 0, 0, 1'b0, 1'b0);
    corrupt_addr = 32'hFFFF_FFFF;
    fill(3);
    run_load(32'd3, 0, 1, 1'b0, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
